ibex_rf_bus_arb: RTL and testbench

Two-requester arbiter sharing the external data memory port between the core load/store path (requester 0) and the register-file spill/fill engine (requester 1). It sits between those requesters and the data bus. Requests are passed through combinationally using the req/gnt/rvalid protocol. Every granted transaction's owner is recorded in an in-order owner FIFO, so each response is routed back to the requester that issued it.

---
 rtl/ibex_rf_bus_arb.sv | 163 ++++++++++++++++
 tb/tb_ibex_rf_bus_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_bus_arb.sv
// Arbiter sharing the data memory port between the core LSU (req 0) and the RF spill/fill engine (req 1).
// Optional `IBEX_RFARB_RR_EN selects round-robin tie-breaking instead of fixed engine priority.
module ibex_rf_bus_arb #(
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             core_req_i,
    output logic             core_gnt_o,
    output logic             core_rvalid_o,
    input  logic             core_we_i,
    input  logic [3:0]       core_be_i,
    input  logic [31:0]      core_addr_i,
    input  logic [31:0]      core_wdata_i,
    output logic [31:0]      core_rdata_o,
    output logic             core_err_o,

    input  logic             rf_req_i,
    output logic             rf_gnt_o,
    output logic             rf_rvalid_o,
    input  logic             rf_we_i,
    input  logic [3:0]       rf_be_i,
    input  logic [31:0]      rf_addr_i,
    input  logic [31:0]      rf_wdata_i,
    output logic [31:0]      rf_rdata_o,
    output logic             rf_err_o,

    output logic             data_req_o,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [31:0]      data_addr_o,
    output logic [31:0]      data_wdata_o,
    input  logic             data_gnt_i,
    input  logic             data_rvalid_i,
    input  logic [31:0]      data_rdata_i,
    input  logic             data_err_i,

    output logic [CntW-1:0]  outstanding_o,
    output logic             spurious_rvalid_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic                      lock_q, lock_d;
    logic                      lock_owner_q, lock_owner_d;
    logic                      sel_valid, sel_owner;
    logic                      push, pop, not_full, head_owner;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [MaxOutstanding-1:0] owner_q;

`ifdef IBEX_RFARB_RR_EN
    logic last_q, last_d;
`endif

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Requester selection: a held lock overrides priority so the stalled request stays stable
    always_comb begin
        sel_valid = 1'b0;
        sel_owner = 1'b0;
        if (lock_q) begin
            sel_owner = lock_owner_q;
            sel_valid = lock_owner_q ? rf_req_i : core_req_i;
        end else if (rf_req_i && core_req_i) begin
            sel_valid = 1'b1;
`ifdef IBEX_RFARB_RR_EN
            sel_owner = ~last_q;
`else
            sel_owner = 1'b1;
`endif
        end else if (rf_req_i) begin
            sel_valid = 1'b1;
            sel_owner = 1'b1;
        end else if (core_req_i) begin
            sel_valid = 1'b1;
            sel_owner = 1'b0;
        end
    end

    assign not_full   = (cnt_q < CntW'(MaxOutstanding));
    assign data_req_o = sel_valid & not_full;

    always_comb begin
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (sel_valid) begin
            data_we_o    = sel_owner ? rf_we_i    : core_we_i;
            data_be_o    = sel_owner ? rf_be_i    : core_be_i;
            data_addr_o  = sel_owner ? rf_addr_i  : core_addr_i;
            data_wdata_o = sel_owner ? rf_wdata_i : core_wdata_i;
        end
    end

    assign push       = data_req_o & data_gnt_i;
    assign core_gnt_o = push & ~sel_owner;
    assign rf_gnt_o   = push & sel_owner;

    assign lock_d       = data_req_o & ~data_gnt_i;
    assign lock_owner_d = lock_d ? sel_owner : 1'b0;

    // Response routing from the registered FIFO head; responses on an empty FIFO are dropped
    assign head_owner        = owner_q[rd_ptr_q];
    assign pop               = data_rvalid_i & (cnt_q != '0);
    assign spurious_rvalid_o = data_rvalid_i & (cnt_q == '0);
    assign core_rvalid_o     = pop & ~head_owner;
    assign rf_rvalid_o       = pop & head_owner;
    assign core_rdata_o      = core_rvalid_o ? data_rdata_i : '0;
    assign rf_rdata_o        = rf_rvalid_o   ? data_rdata_i : '0;
    assign core_err_o        = core_rvalid_o & data_err_i;
    assign rf_err_o          = rf_rvalid_o   & data_err_i;
    assign outstanding_o     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

`ifdef IBEX_RFARB_RR_EN
    assign last_d = push ? sel_owner : last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            owner_q      <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            cnt_q        <= cnt_d;
            if (push) begin
                owner_q[wr_ptr_q] <= sel_owner;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

endmodule

// File: tb/tb_ibex_rf_bus_arb.sv
// Directed bench for ibex_rf_bus_arb (MaxOutstanding=2) with immediate-assertion checks.
module tb_ibex_rf_bus_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i, core_gnt_o, core_rvalid_o, core_we_i, core_err_o;
    logic [3:0]  core_be_i;
    logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
    logic        rf_req_i, rf_gnt_o, rf_rvalid_o, rf_we_i, rf_err_o;
    logic [3:0]  rf_be_i;
    logic [31:0] rf_addr_i, rf_wdata_i, rf_rdata_o;
    logic        data_req_o, data_we_o, data_gnt_i, data_rvalid_i, data_err_i;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [1:0]  outstanding_o;
    logic        spurious_rvalid_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ibex_rf_bus_arb #(.MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_we_i(core_we_i), .core_be_i(core_be_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
        .rf_req_i(rf_req_i), .rf_gnt_o(rf_gnt_o), .rf_rvalid_o(rf_rvalid_o),
        .rf_we_i(rf_we_i), .rf_be_i(rf_be_i), .rf_addr_i(rf_addr_i),
        .rf_wdata_i(rf_wdata_i), .rf_rdata_o(rf_rdata_o), .rf_err_o(rf_err_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
        .outstanding_o(outstanding_o), .spurious_rvalid_o(spurious_rvalid_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs shortly after the clock edge and let them settle before checking
    task automatic drive(input logic creq, input logic [31:0] caddr,
                         input logic rreq, input logic [31:0] raddr,
                         input logic gnt, input logic rvalid, input logic [31:0] rdata);
        core_req_i    = creq;
        core_addr_i   = caddr;
        rf_req_i      = rreq;
        rf_addr_i     = raddr;
        data_gnt_i    = gnt;
        data_rvalid_i = rvalid;
        data_rdata_i  = rdata;
        #2;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic second_tie_rf;
`ifdef IBEX_RFARB_RR_EN
        second_tie_rf = 1'b0;
`else
        second_tie_rf = 1'b1;
`endif
        rst_ni       = 1'b1;
        core_we_i    = 1'b0;
        core_be_i    = 4'hF;
        core_wdata_i = 32'h0;
        rf_we_i      = 1'b1;
        rf_be_i      = 4'h3;
        rf_wdata_i   = 32'hCAFE;
        data_err_i   = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("rst_data_req", 32'(data_req_o), 32'd0);
        chk("rst_gnts", 32'({core_gnt_o, rf_gnt_o}), 32'd0);
        chk("rst_rvalids", 32'({core_rvalid_o, rf_rvalid_o, spurious_rvalid_o}), 32'd0);
        chk("rst_rdata", core_rdata_o | rf_rdata_o, 32'd0);
        tick();
        tick();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Core-only read
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("core_gnt", 32'(core_gnt_o), 32'd1);
        chk("core_addr", data_addr_o, 32'h100);
        chk("core_only_rf_gnt", 32'(rf_gnt_o), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("core_rvalid", 32'(core_rvalid_o), 32'd1);
        chk("core_rdata", core_rdata_o, 32'hDEADBEEF);
        chk("core_rd_rf_rvalid", 32'(rf_rvalid_o), 32'd0);
        chk("core_rd_rf_rdata", rf_rdata_o, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("core_rd_drained", 32'(outstanding_o), 32'd0);

        // Tie: engine wins first; second tie depends on arbitration mode
        drive(1'b1, 32'h104, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        chk("tie1_rf_gnt", 32'(rf_gnt_o), 32'd1);
        chk("tie1_core_gnt", 32'(core_gnt_o), 32'd0);
        chk("tie1_addr", data_addr_o, 32'h200);
        chk("tie1_we", 32'(data_we_o), 32'd1);
        tick();
        drive(1'b1, 32'h104, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        chk("tie2_rf_gnt", 32'(rf_gnt_o), 32'(second_tie_rf));
        chk("tie2_core_gnt", 32'(core_gnt_o), 32'(!second_tie_rf));
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11);
        chk("tie_out2", 32'(outstanding_o), 32'd2);
        chk("tie_resp1_rf", 32'(rf_rvalid_o), 32'd1);
        chk("tie_resp1_rdata", rf_rdata_o, 32'h11);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h22);
        chk("tie_resp2_rf", 32'(rf_rvalid_o), 32'(second_tie_rf));
        chk("tie_resp2_core", 32'(core_rvalid_o), 32'(!second_tie_rf));
        tick();

        // Lock: core stalled 3 cycles, engine arrives in cycle 2
        drive(1'b1, 32'h300, 1'b0, 32'h400, 1'b0, 1'b0, 32'h0);
        chk("lock_c1_addr", data_addr_o, 32'h300);
        chk("lock_c1_req", 32'(data_req_o), 32'd1);
        chk("lock_c1_gnt", 32'(core_gnt_o), 32'd0);
        tick();
        drive(1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
        chk("lock_c2_addr", data_addr_o, 32'h300);
        tick();
        drive(1'b1, 32'h300, 1'b1, 32'h400, 1'b1, 1'b0, 32'h0);
        chk("lock_c3_addr", data_addr_o, 32'h300);
        chk("lock_c3_core_gnt", 32'(core_gnt_o), 32'd1);
        chk("lock_c3_rf_gnt", 32'(rf_gnt_o), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h400, 1'b1, 1'b0, 32'h0);
        chk("lock_rf_gnt", 32'(rf_gnt_o), 32'd1);
        chk("lock_rf_addr", data_addr_o, 32'h400);
        tick();

        // Full FIFO: no issue, not even alongside a pop
        drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("full_out", 32'(outstanding_o), 32'd2);
        chk("full_req", 32'(data_req_o), 32'd0);
        chk("full_gnt", 32'(core_gnt_o), 32'd0);
        tick();
        drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b1, 32'h7);
        chk("full_pop_req", 32'(data_req_o), 32'd0);
        chk("full_pop_core_rvalid", 32'(core_rvalid_o), 32'd1);
        chk("full_pop_rdata", core_rdata_o, 32'h7);
        tick();
        drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("after_full_out", 32'(outstanding_o), 32'd1);
        chk("after_full_req", 32'(data_req_o), 32'd1);
        chk("after_full_gnt", 32'(core_gnt_o), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8);
        chk("drain_rf", 32'(rf_rvalid_o), 32'd1);
        chk("drain_rf_rdata", rf_rdata_o, 32'h8);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h9);
        chk("drain_core", 32'(core_rvalid_o), 32'd1);
        tick();

        // Interleaved owners core, rf, core with overlapping push/pop
        drive(1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("il_core_gnt", 32'(core_gnt_o), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h700, 1'b1, 1'b1, 32'h1);
        chk("il_r1_core", 32'(core_rvalid_o), 32'd1);
        chk("il_r1_rdata", core_rdata_o, 32'h1);
        chk("il_rf_gnt", 32'(rf_gnt_o), 32'd1);
        tick();
        drive(1'b1, 32'h604, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2);
        chk("il_out_pushpop", 32'(outstanding_o), 32'd1);
        chk("il_r2_rf", 32'(rf_rvalid_o), 32'd1);
        chk("il_r2_rdata", rf_rdata_o, 32'h2);
        chk("il_r2_core_rvalid", 32'(core_rvalid_o), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3);
        chk("il_r3_core", 32'(core_rvalid_o), 32'd1);
        chk("il_r3_rdata", core_rdata_o, 32'h3);
        tick();

        // Spurious response on empty FIFO
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h55);
        chk("spur_pulse", 32'(spurious_rvalid_o), 32'd1);
        chk("spur_rvalids", 32'({core_rvalid_o, rf_rvalid_o}), 32'd0);
        chk("spur_rdata", core_rdata_o | rf_rdata_o, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("spur_done", 32'(spurious_rvalid_o), 32'd0);
        chk("spur_out", 32'(outstanding_o), 32'd0);

        // Reset with two outstanding
        drive(1'b1, 32'h800, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h804, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("pre_rst_out", 32'(outstanding_o), 32'd2);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_out", 32'(outstanding_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAA);
        chk("post_rst_spur", 32'(spurious_rvalid_o), 32'd1);
        chk("post_rst_rvalids", 32'({core_rvalid_o, rf_rvalid_o}), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
